spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  Host-side SPI mode-0 master that generates sclk_pin/cs_pin/mosi_pin frames for the spiMemory slave
//  and captures miso_pin. Directly upstream of the slave; test harness/host logic drives it via a valid/ready request port.
//  One frame = 16 bits MSB-first: byte0 = {addr[6:0], rw} (rw=1 read), byte1 = write data, or read data on miso.
// PARAMETERS
//  SCLK_HALF  8  clk cycles per sclk half-period; must be >=4 (covers slave input-conditioner latency), elaborate-time check
//  CS_SETUP   4  clk cycles cs low before first sclk rise
//  CS_HOLD    4  clk cycles after last sclk fall before cs high
//  CS_GAP     8  minimum clk cycles cs high between frames
// PORTS
//  clk          in   1  system clock, all logic rising-edge
//  rst_n        in   1  asynchronous active-low reset
//  req_valid    in   1  request offered
//  req_ready    out  1  block idle, request accepted when valid&ready
//  req_rw       in   1  1=read, 0=write
//  req_addr     in   7  memory address
//  req_wdata    in   8  write data (ignored on read)
//  rsp_valid    out  1  one-cycle pulse, frame (or verify pair) complete
//  rsp_rdata    out  8  read data; 8'h00 after plain write
//  rsp_mismatch out  1  valid with rsp_valid; write-verify failure (0 when macro off)
//  busy         out  1  high from accept until back in IDLE
//  sclk_pin     out  1  SPI clock, idles low
//  cs_pin       out  1  SPI chip select, active low, idles high
//  mosi_pin     out  1  master out
//  miso_pin     in   1  master in (slave output; may float when slave not driving)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, sclk_pin=0, cs_pin=1, mosi_pin=0, req_ready=1 after release, rsp_valid=0,
//   rsp_rdata=0, rsp_mismatch=0, busy=0; counters cleared. Reset mid-frame: cs_pin high immediately, no rsp_valid.
//  FSM IDLE->CSS->SHIFT->CSH->GAP->IDLE.
//   IDLE: req_ready=1; on valid&ready latch {rw,addr,wdata} into 16-bit tx shift reg, cs_pin=0, go CSS.
//   CSS: CS_SETUP cycles, mosi_pin = tx[15]; then SHIFT.
//   SHIFT: 16 bits, each 2*SCLK_HALF cycles: low phase then high phase. mosi_pin changes only on first cycle of low phase.
//    miso sampled on last cycle of high phase; rx shifted in for bits 8..15 only. After bit 15 high phase, sclk_pin=0, go CSH.
//   CSH: CS_HOLD cycles, sclk low; then cs_pin=1, go GAP.
//   GAP: CS_GAP cycles; rsp_valid pulses on first GAP cycle with rsp_rdata = rx (read) or 8'h00 (write); then IDLE.
//  Latency accept->rsp_valid = 1 + CS_SETUP + 32*SCLK_HALF + CS_HOLD cycles (defaults: 265). Accept->next req_ready: +CS_GAP.
//  req_valid while busy: ignored, req_ready=0, no queuing. Inputs sampled only on accept cycle.
//  sclk_pin/cs_pin/mosi_pin are registered outputs (glitch-free).
// CONFIGURATION
//  SPI_MASTER_WRITE_VERIFY_EN defined: every write is followed automatically (after its GAP) by a read frame to the same
//   address; no rsp_valid after the write frame; rsp_valid after the read frame with rsp_rdata=readback,
//   rsp_mismatch=(readback!=wdata). Read requests unchanged, rsp_mismatch=0. busy stays high across both frames.
//  Not defined: single frame per request, rsp_mismatch tied 0.
// STRUCTURE
//  Package spi_master_pkg: state enum (IDLE,CSS,SHIFT,CSH,GAP), FRAME_BITS=16, ADDR_BITS=7, DATA_BITS=8, RW_READ=1'b1.
//  Sub-module spi_master_sclk_gen: half-period divider, outputs phase, rise_stb, fall_stb and sample_stb;
//   enabled by FSM in SHIFT; restarts counter at 0 on enable.
//  Top holds FSM, tx/rx shift regs, bit counter (0..15), setup/hold/gap counter, verify logic.
// TESTING
//  Bench: behavioural SPI slave model (mode 0, 128x8 memory, samples mosi on rise, drives miso after fall).
//  1 Write addr 7'h15 data 8'hA5 -> mosi bits 0x2A,0xA5 MSB-first; model mem[0x15]=A5; rsp_valid at cycle 265, rdata=00.
//  2 Read addr 7'h15 after (1) -> byte0 0x2B; rsp_rdata=8'hA5, mismatch=0; cs high exactly CS_HOLD after last fall.
//  3 Back-to-back req_valid held high for 3 requests -> req_ready low while busy; cs high >=8 cycles between frames.
//  4 Assert rst_n=0 during bit 5 of a frame -> cs_pin=1, sclk_pin=0 same cycle; no rsp_valid; next request runs clean.
//  5 Macro on, model forced to corrupt mem bit0 on write of 8'h3C to 7'h01 -> single rsp_valid, rdata=3D, mismatch=1.
//  6 SCLK_HALF=4: write/read 7'h7F data 8'hFF/8'h00 -> correct data; latency 1+4+128+4=137 cycles.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI mode-0 frame master.
// Frame layout: {addr[6:0], rw} then one data byte, MSB first.
`timescale 1ns/1ps
package spi_master_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;

    localparam logic RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CSS,
        SHIFT,
        CSH,
        GAP
    } state_e;

    // Read frames carry zeros in the data byte; the slave drives miso instead.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic                 rw,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] wdata
    );
        return {addr, rw, (rw == RW_READ) ? {DATA_BITS{1'b0}} : wdata};
    endfunction

endpackage

// File: rtl/spi_master_sclk_gen.sv
// SPI clock divider: SCLK_HALF clk cycles per half-period, low phase first.
// Counter and phase restart from zero whenever the enable drops.
`timescale 1ns/1ps
module spi_master_sclk_gen #(
    parameter int SCLK_HALF = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic phase_o,
    output logic rise_stb_o,
    output logic fall_stb_o,
    output logic sample_stb_o
);

    localparam int            CW   = $clog2(SCLK_HALF + 1);
    localparam logic [CW-1:0] LAST = CW'(SCLK_HALF - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (at_last) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    assign phase_o      = phase_q;
    assign rise_stb_o   = en_i && at_last && !phase_q;
    assign fall_stb_o   = en_i && at_last && phase_q;
    // miso is taken on the last high cycle, just before sclk falls.
    assign sample_stb_o = en_i && at_last && phase_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master issuing 16-bit read/write frames to the spiMemory slave.
// Define SPI_MASTER_WRITE_VERIFY_EN to follow every write with a readback check.
`timescale 1ns/1ps
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int SCLK_HALF = 8,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int CS_GAP    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rw,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 rsp_mismatch,
    output logic                 busy,
    output logic                 sclk_pin,
    output logic                 cs_pin,
    output logic                 mosi_pin,
    input  logic                 miso_pin
);

    generate
        if (SCLK_HALF < 4) begin : g_bad_sclk_half
            $error("SCLK_HALF must be at least 4");
        end
    endgenerate

    localparam int               BIT_W      = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_RX0    = BIT_W'(FRAME_BITS - DATA_BITS);
    localparam logic [7:0]       SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0]       HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0]       GAP_LAST   = 8'(CS_GAP - 1);

    state_e                  state_q;
    logic [FRAME_BITS-1:0]   tx_q;
    logic [DATA_BITS-1:0]    rx_q;
    logic [BIT_W-1:0]        bit_q;
    logic [7:0]              cnt_q;
    logic                    rw_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    rsp_valid_q;
    logic [DATA_BITS-1:0]    rsp_rdata_q;
    logic                    cs_q;
    logic                    mosi_q;

`ifdef SPI_MASTER_WRITE_VERIFY_EN
    logic [ADDR_BITS-1:0]    addr_q;
    logic [DATA_BITS-1:0]    wdata_q;
    logic                    vfy_q;
    logic                    mism_q;
`endif

    logic sclk_en;
    logic sclk_phase;
    logic fall_stb;
    logic sample_stb;
    logic unused_rise_stb;

    assign sclk_en = (state_q == SHIFT);

    spi_master_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (sclk_en),
        .phase_o      (sclk_phase),
        .rise_stb_o   (unused_rise_stb),
        .fall_stb_o   (fall_stb),
        .sample_stb_o (sample_stb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
            addr_q      <= '0;
            wdata_q     <= '0;
            vfy_q       <= 1'b0;
            mism_q      <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        tx_q    <= pack_frame(req_rw, req_addr, req_wdata);
                        mosi_q  <= req_addr[ADDR_BITS-1];
                        rw_q    <= req_rw;
                        cs_q    <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CSS;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        vfy_q   <= (req_rw != RW_READ);
`endif
                    end
                end
                CSS: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (sample_stb && (bit_q >= BIT_RX0)) begin
                        rx_q <= {rx_q[DATA_BITS-2:0], miso_pin};
                    end
                    // mosi moves at the fall so it settles through the low phase.
                    if (fall_stb) begin
                        tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
                        mosi_q <= tx_q[FRAME_BITS-2];
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
                            state_q <= CSH;
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                        end
                    end
                end
                CSH: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        cs_q    <= 1'b1;
                        state_q <= GAP;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
                        if (rw_q == RW_READ) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rx_q;
                            mism_q      <= vfy_q && (rx_q != wdata_q);
                        end
`else
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (rw_q == RW_READ) ? rx_q : '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
                        if (rw_q != RW_READ) begin
                            tx_q    <= pack_frame(RW_READ, addr_q, '0);
                            mosi_q  <= addr_q[ADDR_BITS-1];
                            rw_q    <= RW_READ;
                            cs_q    <= 1'b0;
                            bit_q   <= '0;
                            state_q <= CSS;
                        end else begin
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
`else
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sclk_pin  = sclk_phase;
    assign cs_pin    = cs_q;
    assign mosi_pin  = mosi_q;

`ifdef SPI_MASTER_WRITE_VERIFY_EN
    assign rsp_mismatch = mism_q;
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (SCLK_HALF 8 and 4) share one
// behavioural mode-0 SPI memory slave selected by sel.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

`ifdef SPI_MASTER_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel;
    logic       req_valid;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;

    logic       a_ready, a_rsp_valid, a_mism, a_busy, a_sclk, a_cs, a_mosi;
    logic [7:0] a_rdata;
    logic       b_ready, b_rsp_valid, b_mism, b_busy, b_sclk, b_cs, b_mosi;
    logic [7:0] b_rdata;

    logic       v_ready, v_rsp_valid, v_mism, v_busy, v_sclk, v_cs, v_mosi;
    logic [7:0] v_rdata;

    logic s_miso = 1'b0;

    spi_master_ctrl #(
        .SCLK_HALF (8), .CS_SETUP (4), .CS_HOLD (4), .CS_GAP (8)
    ) u_a (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid & ~sel), .req_ready (a_ready),
        .req_rw (req_rw), .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (a_rsp_valid), .rsp_rdata (a_rdata),
        .rsp_mismatch (a_mism), .busy (a_busy),
        .sclk_pin (a_sclk), .cs_pin (a_cs), .mosi_pin (a_mosi),
        .miso_pin (s_miso)
    );

    spi_master_ctrl #(
        .SCLK_HALF (4), .CS_SETUP (4), .CS_HOLD (4), .CS_GAP (8)
    ) u_b (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid & sel), .req_ready (b_ready),
        .req_rw (req_rw), .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (b_rsp_valid), .rsp_rdata (b_rdata),
        .rsp_mismatch (b_mism), .busy (b_busy),
        .sclk_pin (b_sclk), .cs_pin (b_cs), .mosi_pin (b_mosi),
        .miso_pin (s_miso)
    );

    assign v_ready     = sel ? b_ready     : a_ready;
    assign v_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign v_rdata     = sel ? b_rdata     : a_rdata;
    assign v_mism      = sel ? b_mism      : a_mism;
    assign v_busy      = sel ? b_busy      : a_busy;
    assign v_sclk      = sel ? b_sclk      : a_sclk;
    assign v_cs        = sel ? b_cs        : a_cs;
    assign v_mosi      = sel ? b_mosi      : a_mosi;

    // Slave model: 128x8 memory, samples mosi on rise, drives miso after fall.
    logic [7:0]  mem [128] = '{default: 8'h96};
    logic [4:0]  s_cnt;
    logic [7:0]  s_sh;
    logic [6:0]  s_addr;
    logic        s_rw;
    logic [15:0] s_frame;
    logic        corrupt;

    always @(posedge v_sclk or posedge v_cs) begin
        if (v_cs) begin
            s_cnt <= '0;
        end else begin
            if (s_cnt == 5'd7) begin
                s_addr <= s_sh[6:0];
                s_rw   <= v_mosi;
            end
            if (s_cnt == 5'd15 && !s_rw)
                mem[s_addr] <= {s_sh[6:0], v_mosi} ^ {7'd0, corrupt};
            s_sh    <= {s_sh[6:0], v_mosi};
            s_frame <= {s_frame[14:0], v_mosi};
            s_cnt   <= s_cnt + 5'd1;
        end
    end

    always @(negedge v_sclk) begin
        if (!v_cs && s_rw && s_cnt >= 5'd8 && s_cnt <= 5'd15)
            s_miso <= mem[s_addr][3'(5'd15 - s_cnt)];
    end

    // Measures clk cycles from the last sclk fall to cs rising.
    int   cyc = 0;
    int   t_fall = 0;
    int   hold = 0;
    logic p_sclk = 1'b0;
    logic p_cs = 1'b1;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        p_sclk <= v_sclk;
        p_cs   <= v_cs;
        if (p_sclk && !v_sclk) t_fall <= cyc;
        if (!p_cs && v_cs) hold <= cyc - t_fall;
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic rw, input logic [6:0] a,
                          input logic [7:0] d, output logic [7:0] rd,
                          output logic mm, output int lat, output int np);
        int n;
        int bad;
        bit done;
        rd = '0; mm = 1'b0; lat = -1; np = 0; bad = 0;
        @(negedge clk);
        n = 0;
        while (!v_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", v_ready, 1);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_addr = ~a; req_wdata = 8'hEE; req_rw = ~rw;
        chk("busy_ready_after_accept", {v_busy, v_ready}, 2'b10);
        n = 1;
        done = 1'b0;
        while (!done) begin
            if (v_rsp_valid) begin
                np++;
                if (np == 1) begin
                    rd = v_rdata; mm = v_mism; lat = n;
                end
            end
            if (v_busy && v_ready) bad++;
            if (!v_busy || n >= 3000) done = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("req_completes", n < 3000, 1);
        chk("no_ready_while_busy", bad, 0);
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic [7:0] exp_b0;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [7:0] rd;
        logic       mm;
        int         lat, np, n;
        int         acc, nrsp, falls, run, min_gap, bad;
        logic       pend, pcs;
        logic [7:0] exp_rd;
        int         exp_lat;

        vt[0] = '{1'b0, 7'h15, 8'hA5, 8'h00, 8'h2A};
        vt[1] = '{1'b1, 7'h15, 8'h33, 8'hA5, 8'h2B};
        vt[2] = '{1'b0, 7'h00, 8'h5A, 8'h00, 8'h00};
        vt[3] = '{1'b1, 7'h00, 8'hC3, 8'h5A, 8'h01};
        vt[4] = '{1'b0, 7'h7F, 8'h81, 8'h00, 8'hFE};
        vt[5] = '{1'b1, 7'h7F, 8'h00, 8'h81, 8'hFF};
        vt[6] = '{1'b1, 7'h42, 8'h00, 8'h96, 8'h85};

        rst_n = 1'b0; sel = 1'b0; corrupt = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_cs", a_cs, 1);
        chk("reset_sclk_mosi", {a_sclk, a_mosi}, 0);
        chk("reset_rsp", {a_rsp_valid, a_rdata, a_mism}, 0);
        chk("reset_busy", a_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", a_ready, 1);

        for (int i = 0; i < 7; i++) begin
            do_req(vt[i].rw, vt[i].addr, vt[i].wdata, rd, mm, lat, np);
            exp_rd  = vt[i].rw ? vt[i].exp_rd : (VFY ? vt[i].wdata : 8'h00);
            exp_lat = (vt[i].rw || !VFY) ? 265 : 537;
            chk($sformatf("v%0d_rdata", i), rd, exp_rd);
            chk($sformatf("v%0d_mismatch", i), mm, 0);
            chk($sformatf("v%0d_pulses", i), np, 1);
            chk($sformatf("v%0d_latency", i), lat, exp_lat);
            chk($sformatf("v%0d_mosi_b0", i), s_frame[15:8],
                vt[i].exp_b0 | {7'd0, VFY});
            if (!vt[i].rw && !VFY)
                chk($sformatf("v%0d_mosi_b1", i), s_frame[7:0], vt[i].wdata);
            chk($sformatf("v%0d_cs_hold", i), hold, 4);
        end

        // Three back-to-back writes with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h10; req_wdata = 8'h01;
        acc = 0; nrsp = 0; falls = 0; run = 0; min_gap = 1000; bad = 0;
        pend = 1'b0; pcs = v_cs; n = 0;
        while (n < 4000 && !(acc == 3 && nrsp == 3 && !v_busy)) begin
            if (pend) begin
                acc++;
                pend = 1'b0;
                if (acc < 3) begin
                    req_addr = 7'h10 + 7'(acc);
                    req_wdata = 8'(acc + 1);
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (req_valid && v_ready) pend = 1'b1;
            if (v_busy && v_ready) bad++;
            if (v_rsp_valid) nrsp++;
            if (pcs && !v_cs) begin
                if (falls > 0 && run < min_gap) min_gap = run;
                falls++;
            end
            run = v_cs ? run + 1 : 0;
            pcs = v_cs;
            @(negedge clk);
            n++;
        end
        chk("b2b_accepts", acc, 3);
        chk("b2b_responses", nrsp, 3);
        chk("b2b_no_ready_busy", bad, 0);
        chk("b2b_cs_gap_ge8", min_gap >= 8, 1);
        chk("b2b_frames", falls, VFY ? 6 : 3);
        do_req(1'b1, 7'h11, 8'h00, rd, mm, lat, np);
        chk("b2b_readback", rd, 8'h02);

        // Reset during bit 5 of a write that would overwrite 0x15.
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h15; req_wdata = 8'h11;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(s_cnt == 5'd5 && !v_sclk && !v_cs) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_bit5", n < 1000, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_sclk", {v_cs, v_sclk}, 2'b10);
        chk("abort_busy", v_busy, 0);
        np = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (v_rsp_valid) np++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (v_rsp_valid) np++;
        end
        chk("abort_no_rsp", np, 0);
        chk("abort_ready", v_ready, 1);
        do_req(1'b1, 7'h15, 8'h00, rd, mm, lat, np);
        chk("abort_mem_kept", rd, 8'hA5);
        chk("abort_next_latency", lat, 265);
        chk("abort_next_b0", s_frame[15:8], 8'h2B);

`ifdef SPI_MASTER_WRITE_VERIFY_EN
        corrupt = 1'b1;
        do_req(1'b0, 7'h01, 8'h3C, rd, mm, lat, np);
        corrupt = 1'b0;
        chk("vfy_pulses", np, 1);
        chk("vfy_rdata", rd, 8'h3D);
        chk("vfy_mismatch", mm, 1);
        do_req(1'b0, 7'h02, 8'h77, rd, mm, lat, np);
        chk("vfy_ok_rdata", rd, 8'h77);
        chk("vfy_ok_mismatch", mm, 0);
`endif

        // Fast instance: SCLK_HALF = 4.
        @(negedge clk);
        sel = 1'b1;
        do_req(1'b0, 7'h7F, 8'hFF, rd, mm, lat, np);
        chk("fast_w_latency", lat, VFY ? 281 : 137);
        chk("fast_w_rdata", rd, VFY ? 8'hFF : 8'h00);
        do_req(1'b1, 7'h7F, 8'h00, rd, mm, lat, np);
        chk("fast_r_rdata", rd, 8'hFF);
        chk("fast_r_latency", lat, 137);
        chk("fast_r_b0", s_frame[15:8], 8'hFF);
        chk("fast_cs_hold", hold, 4);
        do_req(1'b0, 7'h7F, 8'h00, rd, mm, lat, np);
        do_req(1'b1, 7'h7F, 8'hAA, rd, mm, lat, np);
        chk("fast_r2_rdata", rd, 8'h00);
        chk("fast_r2_pulses", np, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
